ddr3_cmd_arb: RTL and testbench

Command arbiter and refresh scheduler between the DDR3 configurator (ddr3_cfg), the memory-controller FSM (ddr3_fsm) and the DDL command port (ddr3_ddl).
- During initialisation it forwards configurator commands.
- After initialisation it forwards FSM command sequences and inserts PRECHARGE-ALL + REFRESH pairs on a tREFI timer.
- Refreshes are postponed up to the JEDEC limit while the FSM is busy.
- Replaces ad-hoc refresh muxing at the top level.

---
 rtl/ddr3_settings.sv | 27 ++
 rtl/ddr3_ref_timer.sv | 63 ++++++
 rtl/ddr3_cmd_arb.sv | 188 ++++++++++++++++++
 tb/tb_ddr3_cmd_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_settings.sv
`default_nettype none
// ============================================================================
// Package  : ddr3_settings
// Brief    : Shared DDR3 command encodings, arbiter states and tREFI helper.
// Revision : 1.0
// ============================================================================
package ddr3_settings;

    // Commands are {ras_n, cas_n, we_n}
    localparam logic [2:0] c_cmd_noop = 3'b111;
    localparam logic [2:0] c_cmd_prec = 3'b010;
    localparam logic [2:0] c_cmd_refr = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_IDLE = 3'd1,
        ST_SEQ  = 3'd2,
        ST_PREC = 3'd3,
        ST_REFR = 3'd4
    } arb_state_t;

    function automatic int trefi_cycles(input int freq_mhz, input int trefi_ns);
        return (freq_mhz * trefi_ns) / 1000;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ddr3_ref_timer.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_ref_timer
// Brief    : tREFI interval timer with owed-refresh counter and overflow flag.
// Revision : 1.0
// ============================================================================
module ddr3_ref_timer
    import ddr3_settings::*;
#(
    parameter int DDR_FREQ_MHZ = 100,
    parameter int TREFI_NS     = 7800,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_enable,
    input  logic       i_refr_xfer,
    output logic [3:0] o_ref_cnt,
    output logic       o_ref_err
);

    localparam int c_trefi_cyc = trefi_cycles(DDR_FREQ_MHZ, TREFI_NS);
    localparam int c_tmr_w     = $clog2(c_trefi_cyc + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(c_trefi_cyc - 1);
    localparam logic [c_tmr_w-1:0] c_tmr_one  = c_tmr_w'(1);
    localparam logic [3:0]         c_max_owed = 4'(MAX_POSTPONE);

    logic [c_tmr_w-1:0] r_tmr;
    logic [3:0]         r_ref_cnt;
    logic               r_ref_err;
    logic               w_tick;

    assign w_tick = i_enable && (r_tmr == c_tmr_last);

    always_ff @(posedge clock) begin
        if (reset || !i_enable || w_tick) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + c_tmr_one;
        end
    end

    // A tick landing on the REFR transfer cancels out.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ref_cnt <= 4'd0;
            r_ref_err <= 1'b0;
        end else if (w_tick && !i_refr_xfer) begin
            if (r_ref_cnt >= c_max_owed) begin
                r_ref_err <= 1'b1;
            end else begin
                r_ref_cnt <= r_ref_cnt + 4'd1;
            end
        end else if (!w_tick && i_refr_xfer && (r_ref_cnt != 4'd0)) begin
            r_ref_cnt <= r_ref_cnt - 4'd1;
        end
    end

    assign o_ref_cnt = r_ref_cnt;
    assign o_ref_err = r_ref_err;

endmodule
`default_nettype wire

// File: rtl/ddr3_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : ddr3_cmd_arb
// Brief    : DDR3 command arbiter: configurator/FSM forwarding plus refresh.
// Revision : 1.0
// ============================================================================
module ddr3_cmd_arb
    import ddr3_settings::*;
#(
    parameter int DDR_FREQ_MHZ = 100,
    parameter int DDR_ROW_BITS = 13,
    parameter int TREFI_NS     = 7800,
    parameter int MAX_POSTPONE = 8,
    parameter int URGENT_LEVEL = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_run_i,
    input  logic                    cfg_req_i,
    output logic                    cfg_rdy_o,
    input  logic [2:0]              cfg_cmd_i,
    input  logic [2:0]              cfg_ba_i,
    input  logic [DDR_ROW_BITS-1:0] cfg_adr_i,
    input  logic                    fsm_req_i,
    input  logic                    fsm_seq_i,
    output logic                    fsm_rdy_o,
    input  logic [2:0]              fsm_cmd_i,
    input  logic [2:0]              fsm_ba_i,
    input  logic [DDR_ROW_BITS-1:0] fsm_adr_i,
    output logic                    ref_pend_o,
    output logic                    ref_done_o,
    output logic [3:0]              ref_cnt_o,
    output logic                    ref_err_o,
    output logic                    ddl_req_o,
    output logic                    ddl_seq_o,
    input  logic                    ddl_rdy_i,
    output logic [2:0]              ddl_cmd_o,
    output logic [2:0]              ddl_ba_o,
    output logic [DDR_ROW_BITS-1:0] ddl_adr_o
);

    localparam logic [DDR_ROW_BITS-1:0] c_adr_a10 = DDR_ROW_BITS'(1 << 10);
    localparam logic [3:0]              c_urgent  = 4'(URGENT_LEVEL);

    arb_state_t r_state, w_state_nxt;

    logic                    r_ddl_req, r_ddl_seq, r_ref_done;
    logic [2:0]              r_ddl_cmd, r_ddl_ba;
    logic [DDR_ROW_BITS-1:0] r_ddl_adr;

    logic                    w_xfer, w_free, w_tmr_en;
    logic                    w_load, w_cfg_take, w_fsm_take, w_refr_xfer, w_seq;
    logic [2:0]              w_cmd, w_ba;
    logic [DDR_ROW_BITS-1:0] w_adr;
    logic [3:0]              w_ref_cnt;
    logic                    w_ref_err;

    // The output register may be reloaded on the same cycle it hands off.
    assign w_xfer   = r_ddl_req && ddl_rdy_i;
    assign w_free   = !r_ddl_req || w_xfer;
    assign w_tmr_en = (r_state != ST_INIT);

    ddr3_ref_timer #(
        .DDR_FREQ_MHZ (DDR_FREQ_MHZ),
        .TREFI_NS     (TREFI_NS),
        .MAX_POSTPONE (MAX_POSTPONE)
    ) u_ref_timer (
        .clock       (clock),
        .reset       (reset),
        .i_enable    (w_tmr_en),
        .i_refr_xfer (w_refr_xfer),
        .o_ref_cnt   (w_ref_cnt),
        .o_ref_err   (w_ref_err)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_cfg_take  = 1'b0;
        w_fsm_take  = 1'b0;
        w_refr_xfer = 1'b0;
        w_cmd       = c_cmd_noop;
        w_ba        = '0;
        w_adr       = '0;
        w_seq       = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (w_free) begin
                    if (cfg_run_i) begin
                        w_state_nxt = ST_IDLE;
                    end else if (cfg_req_i) begin
                        w_cfg_take = 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                if (w_free) begin
                    if ((w_ref_cnt != 4'd0) && (!fsm_req_i || (w_ref_cnt >= c_urgent))) begin
                        w_load      = 1'b1;
                        w_cmd       = c_cmd_prec;
                        w_adr       = c_adr_a10;
                        w_seq       = 1'b1;
                        w_state_nxt = ST_PREC;
                    end else if (fsm_req_i) begin
                        w_fsm_take  = 1'b1;
                        w_state_nxt = fsm_seq_i ? ST_SEQ : ST_IDLE;
                    end
                end
            end
            ST_SEQ: begin
                if (w_free && fsm_req_i) begin
                    w_fsm_take = 1'b1;
                    if (!fsm_seq_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_PREC: begin
                if (w_xfer) begin
                    w_load      = 1'b1;
                    w_cmd       = c_cmd_refr;
                    w_state_nxt = ST_REFR;
                end
            end
            ST_REFR: begin
                if (w_xfer) begin
                    w_refr_xfer = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase

        if (w_cfg_take) begin
            w_load = 1'b1;
            w_cmd  = cfg_cmd_i;
            w_ba   = cfg_ba_i;
            w_adr  = cfg_adr_i;
        end
        if (w_fsm_take) begin
            w_load = 1'b1;
            w_cmd  = fsm_cmd_i;
            w_ba   = fsm_ba_i;
            w_adr  = fsm_adr_i;
            w_seq  = fsm_seq_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_INIT;
            r_ddl_req  <= 1'b0;
            r_ddl_seq  <= 1'b0;
            r_ddl_cmd  <= c_cmd_noop;
            r_ddl_ba   <= '0;
            r_ddl_adr  <= '0;
            r_ref_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ref_done <= w_refr_xfer;
            if (w_load) begin
                r_ddl_req <= 1'b1;
                r_ddl_seq <= w_seq;
                r_ddl_cmd <= w_cmd;
                r_ddl_ba  <= w_ba;
                r_ddl_adr <= w_adr;
            end else if (w_xfer) begin
                r_ddl_req <= 1'b0;
                r_ddl_seq <= 1'b0;
            end
        end
    end

    // Accept strobes are combinational so a requester can advance on the capture edge.
    assign cfg_rdy_o  = w_cfg_take && !reset;
    assign fsm_rdy_o  = w_fsm_take && !reset;
    assign ref_pend_o = (w_ref_cnt != 4'd0);
    assign ref_done_o = r_ref_done;
    assign ref_cnt_o  = w_ref_cnt;
    assign ref_err_o  = w_ref_err;
    assign ddl_req_o  = r_ddl_req;
    assign ddl_seq_o  = r_ddl_seq;
    assign ddl_cmd_o  = r_ddl_cmd;
    assign ddl_ba_o   = r_ddl_ba;
    assign ddl_adr_o  = r_ddl_adr;

endmodule
`default_nettype wire

// File: tb/tb_ddr3_cmd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ddr3_cmd_arb
// Brief    : Self-checking bench for ddr3_cmd_arb with a cycle-level model.
// Revision : 1.0
// ============================================================================
module tb_ddr3_cmd_arb;

    localparam int ROW   = 13;
    localparam int TREFI = 780;

    localparam int A_NONE = 0;
    localparam int A_CFG  = 1;
    localparam int A_FSM  = 2;
    localparam int A_PREC = 3;
    localparam int A_REFR = 4;
    localparam int A_RUN  = 5;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_run_i = 1'b0, cfg_req_i = 1'b0;
    logic [2:0]     cfg_cmd_i = 3'b111, cfg_ba_i = 3'd0;
    logic [ROW-1:0] cfg_adr_i = '0;
    logic           fsm_req_i = 1'b0, fsm_seq_i = 1'b0;
    logic [2:0]     fsm_cmd_i = 3'b111, fsm_ba_i = 3'd0;
    logic [ROW-1:0] fsm_adr_i = '0;
    logic           ddl_rdy_i = 1'b0;

    logic           cfg_rdy_o, fsm_rdy_o, ref_pend_o, ref_done_o, ref_err_o;
    logic [3:0]     ref_cnt_o;
    logic           ddl_req_o, ddl_seq_o;
    logic [2:0]     ddl_cmd_o, ddl_ba_o;
    logic [ROW-1:0] ddl_adr_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    ddr3_cmd_arb dut (
        .clock      (clock),
        .reset      (reset),
        .cfg_run_i  (cfg_run_i),
        .cfg_req_i  (cfg_req_i),
        .cfg_rdy_o  (cfg_rdy_o),
        .cfg_cmd_i  (cfg_cmd_i),
        .cfg_ba_i   (cfg_ba_i),
        .cfg_adr_i  (cfg_adr_i),
        .fsm_req_i  (fsm_req_i),
        .fsm_seq_i  (fsm_seq_i),
        .fsm_rdy_o  (fsm_rdy_o),
        .fsm_cmd_i  (fsm_cmd_i),
        .fsm_ba_i   (fsm_ba_i),
        .fsm_adr_i  (fsm_adr_i),
        .ref_pend_o (ref_pend_o),
        .ref_done_o (ref_done_o),
        .ref_cnt_o  (ref_cnt_o),
        .ref_err_o  (ref_err_o),
        .ddl_req_o  (ddl_req_o),
        .ddl_seq_o  (ddl_seq_o),
        .ddl_rdy_i  (ddl_rdy_i),
        .ddl_cmd_o  (ddl_cmd_o),
        .ddl_ba_o   (ddl_ba_o),
        .ddl_adr_o  (ddl_adr_o)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit             m_live = 0, m_run = 0, m_inseq = 0, m_req = 0, m_seq = 0, m_done = 0, m_err = 0;
    int             m_phase = 0;   // 0: no refresh in flight, 1: PREC queued, 2: REFR queued
    int             m_owed = 0, m_cycles = 0;
    logic [2:0]     m_cmd = 3'b111, m_ba = 3'd0;
    logic [ROW-1:0] m_adr = '0;

    function automatic int decide();
        bit xfer;
        bit free;
        xfer = m_req && ddl_rdy_i;
        free = !m_req || xfer;
        if (!m_run) return free ? (cfg_run_i ? A_RUN : (cfg_req_i ? A_CFG : A_NONE)) : A_NONE;
        if (m_phase == 1) return xfer ? A_REFR : A_NONE;
        if (m_phase == 2 || !free) return A_NONE;
        if (m_inseq) return fsm_req_i ? A_FSM : A_NONE;
        if (m_owed > 0 && (!fsm_req_i || m_owed >= 6)) return A_PREC;
        return fsm_req_i ? A_FSM : A_NONE;
    endfunction

    always @(posedge clock) begin
        int a;
        bit xfer, tick, refr_x;
        if (reset) begin
            m_live <= 1; m_run <= 0; m_inseq <= 0; m_req <= 0; m_seq <= 0;
            m_done <= 0; m_err <= 0; m_phase <= 0; m_owed <= 0; m_cycles <= 0;
            m_cmd <= 3'b111; m_ba <= 3'd0; m_adr <= '0;
        end else if (m_live) begin
            a      = decide();
            xfer   = m_req && ddl_rdy_i;
            tick   = m_run && ((m_cycles % TREFI) == TREFI - 1);
            refr_x = (m_phase == 2) && xfer;
            if (m_run) m_cycles <= m_cycles + 1;
            if (tick && !refr_x) begin
                if (m_owed == 8) m_err <= 1;
                else m_owed <= m_owed + 1;
            end else if (refr_x && !tick) begin
                m_owed <= m_owed - 1;
            end
            m_done <= refr_x;
            if (refr_x) m_phase <= 0;
            if (xfer) begin m_req <= 0; m_seq <= 0; end
            case (a)
                A_RUN: m_run <= 1;
                A_CFG: begin
                    m_req <= 1; m_seq <= 0; m_cmd <= cfg_cmd_i; m_ba <= cfg_ba_i; m_adr <= cfg_adr_i;
                end
                A_FSM: begin
                    m_req <= 1; m_seq <= fsm_seq_i; m_cmd <= fsm_cmd_i; m_ba <= fsm_ba_i; m_adr <= fsm_adr_i;
                    m_inseq <= fsm_seq_i;
                end
                A_PREC: begin
                    m_req <= 1; m_seq <= 1; m_cmd <= 3'b010; m_ba <= 3'd0; m_adr <= 13'h400; m_phase <= 1;
                end
                A_REFR: begin
                    m_req <= 1; m_seq <= 0; m_cmd <= 3'b001; m_ba <= 3'd0; m_adr <= '0; m_phase <= 2;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clock) begin
        int a;
        if (m_live && !reset) begin
            a = decide();
            check("cycle_outputs",
                  {ddl_req_o, ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, cfg_rdy_o, fsm_rdy_o,
                   ref_pend_o, ref_done_o, ref_cnt_o, ref_err_o},
                  {m_req, m_seq, m_cmd, m_ba, m_adr, a == A_CFG, a == A_FSM,
                   m_owed != 0, m_done, 4'(m_owed), m_err});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic fsm_send(input logic [2:0] cmd, input logic [2:0] ba, input logic [ROW-1:0] adr,
                            input logic seq);
        int n;
        fsm_cmd_i = cmd; fsm_ba_i = ba; fsm_adr_i = adr; fsm_seq_i = seq; fsm_req_i = 1'b1;
        n = 0;
        @(negedge clock);
        while (!fsm_rdy_o && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("fsm_rdy_seen", fsm_rdy_o, 1'b1);
        @(posedge clock);
        #1;
        fsm_req_i = 1'b0;
        fsm_seq_i = 1'b0;
    endtask

    initial begin
        int hit;
        // Reset state
        step(3);
        check("rst_req", ddl_req_o, 1'b0);
        check("rst_cmd", ddl_cmd_o, 3'b111);
        check("rst_cnt", ref_cnt_o, 4'd0);
        check("rst_err", ref_err_o, 1'b0);
        reset = 1'b0;

        // Init forwarding; FSM request must be ignored
        ddl_rdy_i = 1'b1;
        fsm_req_i = 1'b1; fsm_cmd_i = 3'b011;
        cfg_cmd_i = 3'b000; cfg_ba_i = 3'd2; cfg_adr_i = 13'h0520; cfg_req_i = 1'b1;
        @(negedge clock);
        check("init_cfg_rdy", cfg_rdy_o, 1'b1);
        check("init_fsm_rdy", fsm_rdy_o, 1'b0);
        @(posedge clock); #1;
        cfg_req_i = 1'b0;
        check("init_ddl", {ddl_req_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o}, {1'b1, 3'b000, 3'd2, 13'h0520});
        @(negedge clock);
        check("init_rdy_once", {cfg_rdy_o, fsm_rdy_o}, 2'b00);
        fsm_req_i = 1'b0;
        step(2);

        // Idle refresh
        cfg_run_i = 1'b1;
        step(1);
        step(779);
        check("idle_cnt_before_tick", ref_cnt_o, 4'd0);
        step(1);
        check("idle_cnt_after_tick", {ref_cnt_o, ref_pend_o, ddl_req_o}, {4'd1, 1'b1, 1'b0});
        step(1);
        check("idle_prec", {ddl_req_o, ddl_cmd_o, ddl_adr_o}, {1'b1, 3'b010, 13'h400});
        step(1);
        check("idle_refr", {ddl_req_o, ddl_cmd_o}, {1'b1, 3'b001});
        step(1);
        check("idle_done", {ref_done_o, ref_cnt_o, ref_pend_o}, {1'b1, 4'd0, 1'b0});

        // Sequence protection: tick lands while ACT is stalled
        step(767);
        ddl_rdy_i = 1'b0;
        fsm_send(3'b011, 3'd1, 13'h0123, 1'b1);
        step(20);
        check("seq_stall_act", {ref_cnt_o, ddl_req_o, ddl_cmd_o, ddl_seq_o}, {4'd1, 1'b1, 3'b011, 1'b1});
        ddl_rdy_i = 1'b1;
        fsm_send(3'b100, 3'd1, 13'h0008, 1'b1);
        check("seq_wr", ddl_cmd_o, 3'b100);
        fsm_send(3'b010, 3'd1, 13'h0000, 1'b0);
        check("seq_pre", {ddl_cmd_o, ddl_adr_o, ddl_seq_o, ref_cnt_o}, {3'b010, 13'h0, 1'b0, 4'd1});
        step(1);
        check("seq_prec_after_pre", {ddl_cmd_o, ddl_adr_o}, {3'b010, 13'h400});
        step(1);
        check("seq_refr", ddl_cmd_o, 3'b001);
        step(1);
        check("seq_done", {ref_done_o, ref_cnt_o}, {1'b1, 4'd0});

        // Postponement and urgency under continuous FSM traffic
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        fsm_req_i = 1'b1; fsm_seq_i = 1'b0; fsm_cmd_i = 3'b101; fsm_ba_i = 3'd3; fsm_adr_i = 13'h00AA;
        hit = -1;
        for (int n = 0; n < 5000; n++) begin
            step(1);
            if (ddl_req_o && ddl_cmd_o == 3'b010) begin
                hit = n;
                break;
            end
        end
        check("urg_cycle", hit, 4681);
        check("urg_prec", {ref_cnt_o, ddl_adr_o, fsm_rdy_o}, {4'd6, 13'h400, 1'b0});
        step(1);
        check("urg_refr", {ddl_cmd_o, fsm_rdy_o, ref_cnt_o}, {3'b001, 1'b0, 4'd6});
        step(1);
        check("urg_resume", {ref_done_o, ref_cnt_o, fsm_rdy_o}, {1'b1, 4'd5, 1'b1});
        fsm_req_i = 1'b0;

        // Overflow with the DDL fully stalled
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        ddl_rdy_i = 1'b0;
        step(1);
        step(780);
        check("ovf_first", {ref_cnt_o, ddl_req_o}, {4'd1, 1'b0});
        step(5465);
        check("ovf_sat", {ref_cnt_o, ref_err_o, ddl_req_o, ddl_cmd_o}, {4'd8, 1'b0, 1'b1, 3'b010});
        step(780);
        check("ovf_err", {ref_cnt_o, ref_err_o}, {4'd8, 1'b1});

        // Stall hold, then reset mid-stall
        step(5);
        check("hold_ddl", {ref_err_o, ddl_req_o, ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o},
              {1'b1, 1'b1, 1'b1, 3'b010, 3'd0, 13'h400});
        fsm_req_i = 1'b1;
        reset = 1'b1;
        step(1);
        check("rst_mid", {ddl_req_o, ddl_seq_o, ddl_cmd_o, ddl_ba_o, ddl_adr_o, ref_cnt_o,
                          ref_err_o, ref_done_o, ref_pend_o},
              {1'b0, 1'b0, 3'b111, 3'd0, 13'h0, 4'd0, 1'b0, 1'b0, 1'b0});
        cfg_run_i = 1'b0;
        reset = 1'b0;
        step(1);
        @(negedge clock);
        check("rst_back_in_init", {fsm_rdy_o, ddl_req_o}, 2'b00);
        fsm_req_i = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
